// File: rtl/fifo_wr_arb_if.sv
// Stream bundle between NREQ sources, the write arbiter and
// the FIFO write port.
interface fifo_wr_arb_if #(
  parameter int NREQ = 4,
  parameter int DLEN = 8
);
  logic [NREQ-1:0]      i_tvalid;
  logic [NREQ-1:0]      o_tready;
  logic [NREQ*DLEN-1:0] i_tdata;
  logic [NREQ-1:0]      i_tlast;
  logic                 o_tvalid;
  logic                 i_tready;
  logic [DLEN-1:0]      o_tdata;
  logic                 o_tlast;
  logic [NREQ-1:0]      o_grant;
  logic                 o_busy;
  logic                 o_timeout;

  modport slave (
    input  i_tvalid, i_tdata, i_tlast, i_tready,
    output o_tready, o_tvalid, o_tdata, o_tlast,
    output o_grant, o_busy, o_timeout
  );

  modport master (
    output i_tvalid, i_tdata, i_tlast, i_tready,
    input  o_tready, o_tvalid, o_tdata, o_tlast,
    input  o_grant, o_busy, o_timeout
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin packet arbiter feeding one FIFO write port.
// Optional idle-source release: FIFO_WR_ARB_TIMEOUT_EN.
module fifo_wr_arb #(
  parameter int NREQ    = 4,
  parameter int DLEN    = 8,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          rstn,
  fifo_wr_arb_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   last_winner;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic            busy;
  logic            xfer;
  logic            xfer_last;

  // Scan upward from the slot after the previous winner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!win_found &&
          bus.i_tvalid[(int'(last_winner) + i) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(last_winner) + i) % NREQ);
      end
    end
  end

  assign busy      = (state == LOCK);
  assign xfer      = bus.o_tvalid & bus.i_tready;
  assign xfer_last = xfer & bus.o_tlast;

  assign bus.o_grant  = grant;
  assign bus.o_busy   = busy;
  assign bus.o_tready = grant & {NREQ{bus.i_tready}};
  assign bus.o_tvalid = busy & bus.i_tvalid[gidx];
  assign bus.o_tlast  = busy & bus.i_tlast[gidx];
  assign bus.o_tdata  = busy ? bus.i_tdata[gidx*DLEN +: DLEN]
                             : '0;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] idle_cnt;
  logic          timeout_q;

  assign bus.o_timeout = timeout_q;
`else
  assign bus.o_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      grant       <= '0;
      gidx        <= '0;
      last_winner <= IW'(NREQ - 1);
`ifdef FIFO_WR_ARB_TIMEOUT_EN
      idle_cnt    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef FIFO_WR_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (win_found) begin
            state <= LOCK;
            grant <= NREQ'(1) << win_idx;
            gidx  <= win_idx;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
        end
        LOCK: begin
          if (xfer_last) begin
            state       <= IDLE;
            grant       <= '0;
            last_winner <= gidx;
          end
`ifdef FIFO_WR_ARB_TIMEOUT_EN
          else if (xfer) begin
            idle_cnt <= '0;
          end else if (!bus.i_tvalid[gidx]) begin
            // FIFO-full stalls never reach here: only a silent source counts.
            if (idle_cnt == CW'(TIMEOUT - 1)) begin
              state       <= IDLE;
              grant       <= '0;
              last_winner <= gidx;
              idle_cnt    <= '0;
              timeout_q   <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
